// File: rtl/note_player_if.sv
// Note handshake between the pattern sequencer (master) and a note player (slave).
// The player pulses note_stb; the sequencer answers with a one-cycle note_valid and the note fields.
interface note_player_if;
    logic       note_stb;
    logic       note_valid;
    logic [5:0] note_pitch;
    logic [4:0] note_len;
    logic [3:0] note_instrument;

    modport master (
        input  note_stb,
        output note_valid, note_pitch, note_len, note_instrument
    );

    modport slave (
        output note_stb,
        input  note_valid, note_pitch, note_len, note_instrument
    );
endinterface

// File: rtl/note_player.sv
// Note player: fetches notes from the sequencer, maps pitch to a phase increment through a
// 1-cycle pitch ROM and holds each note for len+1 tempo ticks. NOTE_PLAYER_GAP_EN adds an articulation gap.
module note_player #(
    parameter int PHASE_WIDTH  = 16,
    parameter int NOTE_TIMEOUT = 15
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_tick,
    note_player_if.slave           note_if,
    output logic [5:0]             o_pitch_rom_addr,
    input  logic [PHASE_WIDTH-1:0] i_pitch_rom_data,
    output logic [PHASE_WIDTH-1:0] o_phase_inc,
    output logic [3:0]             o_instrument,
    output logic                   o_gate,
    output logic                   o_playing,
    output logic                   o_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_WAIT_NOTE, S_ROM_ADDR, S_ROM_DATA, S_PLAYING
    } state_t;

    // Last WAIT_NOTE cycle index; a missing valid on this cycle is the timeout.
    localparam logic [7:0] TMO_LAST = 8'(NOTE_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [7:0]             tmo_q, tmo_d;
    logic [5:0]             addr_q, addr_d;
    logic [4:0]             len_q, len_d;
    logic [4:0]             rem_q, rem_d;
    logic [3:0]             ins_lat_q, ins_lat_d;
    logic [3:0]             ins_q, ins_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                   gate_q, gate_d;
    logic                   err_q, err_d;
    logic                   stb;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            ins_lat_q <= '0;
            ins_q     <= '0;
            phase_q   <= '0;
            gate_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            ins_lat_q <= ins_lat_d;
            ins_q     <= ins_d;
            phase_q   <= phase_d;
            gate_q    <= gate_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rem_d     = rem_q;
        ins_lat_d = ins_lat_q;
        ins_d     = ins_q;
        phase_d   = phase_q;
        gate_d    = gate_q;
        err_d     = err_q;
        stb       = 1'b0;

        case (state_q)
            S_IDLE: begin
                gate_d = 1'b0;
                if (i_enable) state_d = S_REQUEST;
            end
            S_REQUEST: begin
                stb     = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_NOTE;
            end
            S_WAIT_NOTE: begin
                // The address register doubles as the latched pitch, so the ROM sees it next cycle.
                if (note_if.note_valid) begin
                    addr_d    = note_if.note_pitch;
                    len_d     = note_if.note_len;
                    ins_lat_d = note_if.note_instrument;
                    state_d   = S_ROM_ADDR;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    gate_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_ROM_ADDR: state_d = S_ROM_DATA;
            S_ROM_DATA: begin
                phase_d = (addr_q == '0) ? '0 : i_pitch_rom_data;
                ins_d   = ins_lat_q;
                gate_d  = (addr_q != '0);
                rem_d   = len_q;
                state_d = S_PLAYING;
            end
            S_PLAYING: begin
                if (i_tick) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - 5'd1;
`ifdef NOTE_PLAYER_GAP_EN
                        // Entering the final tick period of a multi-tick note: silence it.
                        if (rem_q == 5'd1) gate_d = 1'b0;
`endif
                    end else if (i_enable) begin
                        state_d = S_REQUEST;
                    end else begin
                        gate_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign note_if.note_stb = stb;
    assign o_pitch_rom_addr = addr_q;
    assign o_phase_inc      = phase_q;
    assign o_instrument     = ins_q;
    assign o_gate           = gate_q;
    assign o_playing        = (state_q != S_IDLE);
    assign o_error          = err_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: table of back-to-back notes plus hand sequences for
// enable drop, timeout, sticky error, mid-note reset and stray valid pulses.
module tb_note_player;

`ifdef NOTE_PLAYER_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, tick;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data, phase;
    logic [3:0]  instr;
    logic        gate, playing, err;
    logic [15:0] rom [64];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    note_player_if nif ();

    note_player #(.PHASE_WIDTH(16), .NOTE_TIMEOUT(15)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (en),
        .i_tick           (tick),
        .note_if          (nif),
        .o_pitch_rom_addr (rom_addr),
        .i_pitch_rom_data (rom_data),
        .o_phase_inc      (phase),
        .o_instrument     (instr),
        .o_gate           (gate),
        .o_playing        (playing),
        .o_error          (err)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic [5:0]  p;
        logic [4:0]  l;
        logic [3:0]  ins;
        logic [15:0] ph;
        logic        g;
        bit          late;
    } vec_t;

    vec_t vecs[5];

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [5:0] p, input logic [4:0] l, input logic [3:0] ins);
        nif.note_pitch = p; nif.note_len = l; nif.note_instrument = ins;
        nif.note_valid = 1'b1;
        cyc(1);
        nif.note_valid = 1'b0;
    endtask

    task automatic wait_stb(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (nif.note_stb) begin ok = 1'b1; break; end
            cyc(1);
        end
        check("stb_wait", 32'(ok), 32'd1);
    endtask

    // Ticks spaced 8 cycles apart until the note ends (stb or back to idle).
    task automatic count_ticks(input int len, input logic g, output int n);
        n = 0;
        for (int t = 1; t <= 40; t++) begin
            cyc(7); tick = 1'b1; cyc(1); tick = 1'b0;
            if (nif.note_stb || !playing) begin n = t; break; end
            check("gate_in_note", 32'(gate), 32'((GAP && len > 0 && t == len) ? 1'b0 : g));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] prev_ph;
        logic        prev_g;
        bit          seen;

        for (int i = 0; i < 64; i++) rom[i] = 16'(i * 16'h0101);
        rom[10] = 16'h1234;

        vecs[0] = '{p: 6'd10, l: 5'd2, ins: 4'd5,  ph: 16'h1234, g: 1'b1, late: 1'b0};
        vecs[1] = '{p: 6'd0,  l: 5'd0, ins: 4'd3,  ph: 16'h0000, g: 1'b0, late: 1'b0};
        vecs[2] = '{p: 6'd7,  l: 5'd1, ins: 4'd9,  ph: 16'h0707, g: 1'b1, late: 1'b1};
        vecs[3] = '{p: 6'd63, l: 5'd0, ins: 4'd15, ph: 16'h3F3F, g: 1'b1, late: 1'b0};
        vecs[4] = '{p: 6'd1,  l: 5'd3, ins: 4'd0,  ph: 16'h0101, g: 1'b1, late: 1'b0};

        rst = 1'b1; en = 1'b0; tick = 1'b0;
        nif.note_valid = 1'b0; nif.note_pitch = '0; nif.note_len = '0; nif.note_instrument = '0;
        cyc(3);
        check("rst_stb", 32'(nif.note_stb), 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_gate", 32'(gate), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_error", 32'(err), 0);
        check("rst_addr", 32'(rom_addr), 0);

        rst = 1'b0; en = 1'b1;
        check("stb_1st_cycle", 32'(nif.note_stb), 0);
        cyc(1);
        check("stb_2nd_cycle", 32'(nif.note_stb), 1);

        prev_ph = '0; prev_g = 1'b0;
        for (int v = 0; v < 5; v++) begin
            check("hold_phase_at_stb", 32'(phase), 32'(prev_ph));
            check("hold_gate_at_stb", 32'(gate), 32'(prev_g));
            if (vecs[v].late) begin
                // Tick during WAIT_NOTE, then valid on the last cycle before timeout.
                cyc(8); tick = 1'b1; cyc(1); tick = 1'b0; cyc(6);
            end else begin
                cyc(3);
            end
            send(vecs[v].p, vecs[v].l, vecs[v].ins);
            check("rom_addr", 32'(rom_addr), 32'(vecs[v].p));
            check("hold_gate_fetch", 32'(gate), 32'(prev_g));
            cyc(1);
            check("hold_phase_fetch", 32'(phase), 32'(prev_ph));
            if (vecs[v].late) tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            check("note_phase", 32'(phase), 32'(vecs[v].ph));
            check("note_instr", 32'(instr), 32'(vecs[v].ins));
            check("note_gate", 32'(gate), 32'(vecs[v].g));
            check("note_playing", 32'(playing), 1);
            check("note_error", 32'(err), 0);
            count_ticks(int'(vecs[v].l), vecs[v].g, n);
            check("note_ticks", 32'(n), 32'(vecs[v].l) + 1);
            check("next_stb", 32'(nif.note_stb), 1);
            prev_ph = vecs[v].ph;
            prev_g  = (GAP && vecs[v].l != 0) ? 1'b0 : vecs[v].g;
        end

        // Enable dropped mid-note: note completes, then idle with no new request.
        cyc(3);
        send(6'd5, 5'd3, 4'd2);
        cyc(2);
        check("drop_phase", 32'(phase), 32'h0505);
        en = 1'b0;
        count_ticks(3, 1'b1, n);
        check("drop_ticks", 32'(n), 4);
        check("drop_gate", 32'(gate), 0);
        check("drop_playing", 32'(playing), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (nif.note_stb) seen = 1'b1;
            cyc(1);
        end
        check("drop_no_stb", 32'(seen), 0);

        // Timeout: 15 WAIT_NOTE cycles without valid.
        en = 1'b1;
        wait_stb(5);
        en = 1'b0;
        cyc(15);
        check("tmo_not_yet", 32'(err), 0);
        check("tmo_still_wait", 32'(playing), 1);
        cyc(1);
        check("tmo_error", 32'(err), 1);
        check("tmo_gate", 32'(gate), 0);
        check("tmo_idle", 32'(playing), 0);
        cyc(10);
        check("tmo_sticky", 32'(err), 1);

        // Recovery still plays notes; error stays until reset.
        en = 1'b1;
        wait_stb(5);
        cyc(3);
        send(6'd10, 5'd4, 4'd6);
        cyc(2);
        check("recover_phase", 32'(phase), 32'h1234);
        check("recover_err_sticky", 32'(err), 1);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; en = 1'b0;
        check("midnote_rst_phase", 32'(phase), 0);
        check("midnote_rst_gate", 32'(gate), 0);
        check("midnote_rst_playing", 32'(playing), 0);
        check("midnote_rst_error", 32'(err), 0);
        check("midnote_rst_addr", 32'(rom_addr), 0);

        // Stray valid while idle is ignored.
        send(6'd10, 5'd1, 4'd7);
        cyc(3);
        check("stray_valid_idle", 32'(playing), 0);
        check("stray_valid_addr", 32'(rom_addr), 0);
        check("stray_valid_instr", 32'(instr), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Consumer end of the note interface driven by the pattern sequencer.
- Requests a note with a one-cycle strobe and latches pitch/length/instrument on the valid pulse.
- Converts pitch to an oscillator phase increment through a synchronous pitch ROM.
- Holds the note for a tempo-tick-measured duration, then requests the next one; outputs feed one voice/oscillator channel.

Parameters:
- PHASE_WIDTH, 16, width of pitch ROM data and o_phase_inc.
- NOTE_TIMEOUT, 15, max clock cycles from o_note_stb to i_note_valid before error; 4..255.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_enable  in  1  play enable; sampled only in IDLE and at note end
- i_tick  in  1  tempo tick, one-cycle pulse; spacing must be >= 8 cycles
- o_note_stb  out  1  one-cycle request for next note
- i_note_valid  in  1  note fields valid this cycle (one-cycle pulse)
- i_note_pitch  in  6  pitch index; 0 = rest
- i_note_len  in  5  duration code N; note lasts N+1 ticks
- i_note_instrument  in  4  instrument select
- o_pitch_rom_addr  out  6  pitch ROM address; ROM has 1-cycle read latency
- i_pitch_rom_data  in  PHASE_WIDTH  phase increment for addressed pitch
- o_phase_inc  out  PHASE_WIDTH  current phase increment
- o_instrument  out  4  current instrument
- o_gate  out  1  note sounding
- o_playing  out  1  high in any non-IDLE state
- o_error  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset: state IDLE; o_note_stb=0, o_phase_inc=0, o_instrument=0, o_gate=0, o_playing=0, o_error=0, o_pitch_rom_addr=0; internal counters 0.
- States: IDLE, REQUEST, WAIT_NOTE, ROM_ADDR, ROM_DATA, PLAYING.
- IDLE: if i_enable -> REQUEST; o_gate=0.
- REQUEST: o_note_stb=1 for exactly this cycle; clear timeout counter -> WAIT_NOTE.
- WAIT_NOTE: on i_note_valid latch pitch, len, instrument -> ROM_ADDR.
- WAIT_NOTE timeout: counter increments each cycle without valid; reaching NOTE_TIMEOUT -> o_error=1, o_gate=0, -> IDLE. i_note_valid in the same cycle as timeout wins (note accepted, no error).
- i_note_valid outside WAIT_NOTE: ignored.
- ROM_ADDR: o_pitch_rom_addr = latched pitch -> ROM_DATA. o_pitch_rom_addr holds the last value in all other states.
- ROM_DATA: i_pitch_rom_data is valid.
  - Register o_phase_inc (0 if pitch==0), o_instrument, remaining=len.
  - o_gate = (pitch != 0).
  - All three outputs change together on entry to PLAYING -> PLAYING.
- Between notes (REQUEST..ROM_DATA): o_phase_inc, o_instrument and o_gate hold the previous note's values (legato).
- Latency: i_note_valid to new outputs = 3 clock edges.
- PLAYING, remaining != 0: on i_tick, remaining -= 1.
- PLAYING, remaining == 0, on i_tick:
  - i_enable=1 -> REQUEST.
  - i_enable=0 -> IDLE; o_gate=0 next cycle.
- i_tick outside PLAYING: ignored. Duration counts only ticks seen in PLAYING, so len=N spans exactly N+1 ticks.
- len=0: note ends on the first tick in PLAYING.
- i_enable changes outside IDLE/note-end: no effect; a fetch in progress always completes.
- i_rst in any state: immediate return to reset values next edge, including mid-fetch and mid-note.
- o_playing = (state != IDLE).

Optional Feature:
- Macro: NOTE_PLAYER_GAP_EN.
- Defined: in PLAYING with remaining==0 and len>0, o_gate is forced 0 for the whole final tick period (articulation gap). It reasserts on the next note's entry to PLAYING if that pitch is nonzero. len=0 notes get no gap.
- Undefined: o_gate stays high through the entire note and the fetch (pure legato).

Test Plan:
- Reset, i_enable=1 -> o_note_stb pulses at the 2nd cycle after reset release. Return valid 3 cycles later with pitch=10, len=2, instr=5, ROM[10]=16'h1234 -> o_phase_inc=16'h1234, o_instrument=5, o_gate=1 three edges after valid; next o_note_stb on the 3rd tick.
- pitch=0, len=0 -> o_phase_inc=0, o_gate=0. Next o_note_stb on the first tick after entering PLAYING.
- Withhold i_note_valid for 15 cycles after stb -> o_error=1, o_gate=0, state IDLE; o_error stays 1 until i_rst.
- Drop i_enable mid-note (len=3) -> note still lasts 4 ticks, then o_gate=0 and o_playing=0, with no further o_note_stb.
- Pulse i_tick during WAIT_NOTE/ROM phases -> ignored; note with len=1 still lasts exactly 2 ticks in PLAYING.
- With NOTE_PLAYER_GAP_EN, len=2: o_gate high for 2 ticks, low during the 3rd tick period; without the macro, o_gate stays continuously high across back-to-back notes.
